// File: rtl/d_phy_pkg.sv
// Shared definitions for the HS-only D-PHY data-lane transmitter.
package d_phy_pkg;

   localparam logic [7:0] SYNC_BYTE      = 8'hB8;
   localparam int         BITS_PER_CLOCK = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HS_ZERO = 3'd1,
      SYNC    = 3'd2,
      DATA    = 3'd3,
      TRAILER = 3'd4,
      POST    = 3'd5
   } tx_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/d_phy_byte_serializer.sv
// Byte serializer: presents two bits per clock, LSB first.
// On load the first pair comes straight from load_data so the lane can go
// from the previous byte's last pair to this byte's first pair with no gap;
// the remaining bits are held in pending and shifted out on advance.
module d_phy_byte_serializer
   import d_phy_pkg::*;
(
   input  logic       clock_p,
   input  logic       reset,
   input  logic       load,
   input  logic       advance,
   input  logic [7:0] load_data,
   output logic       pair_h,
   output logic       pair_l
);

   localparam int REM_W = 8 - BITS_PER_CLOCK;

   logic [REM_W-1:0] pending;

   // pair to be sent on the coming clock
   always_comb begin
      pair_h = load ? load_data[0] : pending[0];
      pair_l = load ? load_data[1] : pending[1];
   end

   // hold the not-yet-sent bits of the current byte
   always_ff @(posedge clock_p) begin
      if (reset) begin
         pending <= '0;
      end else if (load) begin
         pending <= load_data[7:BITS_PER_CLOCK];
      end else if (advance) begin
         pending <= pending >> BITS_PER_CLOCK;
      end
   end

endmodule

// File: rtl/d_phy_transmitter.sv
// HS-only D-PHY data-lane transmitter.
// Burst framing: HS-zero, sync byte 0xB8, payload bytes LSB-first, HS-trail,
// then clock-post with the lane clock still running and the driver off.
// Optional build macro D_PHY_TX_DISPLAY_EN: prints each transferred byte
// ("%h") in simulation, matching the receiver's per-byte log. Hardware is
// identical with or without it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | driver off, lane clock off, waiting for in_valid
// HS_ZERO | driver on, pair 00 for ZERO_CYCLES clocks
// SYNC    | four clocks of sync byte 0xB8, byte request on slot 3
// DATA    | four clocks per payload byte, next byte requested on slot 3
// TRAILER | inverted last bit on both lines for TRAIL_CYCLES clocks
// POST    | driver off, lane clock on for CLK_POST_CYCLES clocks
module d_phy_transmitter
   import d_phy_pkg::*;
#(
   parameter int ZERO_CYCLES     = 16,
   parameter int TRAIL_CYCLES    = 4,
   parameter int CLK_POST_CYCLES = 8
) (
   input  logic       clock_p,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       data_h,
   output logic       data_l,
   output logic       hs_active,
   output logic       clock_enable,
   output logic       busy
);

   localparam int CNT_W = $clog2(max3(ZERO_CYCLES, TRAIL_CYCLES, CLK_POST_CYCLES) + 1);

   localparam logic [CNT_W-1:0] ZERO_LOAD  = CNT_W'(ZERO_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRAIL_LOAD = CNT_W'(TRAIL_CYCLES - 1);
   localparam logic [CNT_W-1:0] POST_LOAD  = CNT_W'(CLK_POST_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = IDLE;
   localparam logic [2:0] S_HS_ZERO = HS_ZERO;
   localparam logic [2:0] S_SYNC    = SYNC;
   localparam logic [2:0] S_DATA    = DATA;
   localparam logic [2:0] S_TRAILER = TRAILER;
   localparam logic [2:0] S_POST    = POST;

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]       slot, slot_nxt;
   logic             h_nxt, l_nxt, hs_nxt, ce_nxt;
   logic             ser_load, ser_advance;
   logic [7:0]       ser_data;
   logic             ser_h, ser_l;
   logic             slot_last;

   assign slot_last = (slot == 2'd3);
   assign in_ready  = ((state == S_SYNC) || (state == S_DATA)) && slot_last;
   assign busy      = (state != S_IDLE);

   d_phy_byte_serializer u_ser (
      .clock_p   (clock_p),
      .reset     (reset),
      .load      (ser_load),
      .advance   (ser_advance),
      .load_data (ser_data),
      .pair_h    (ser_h),
      .pair_l    (ser_l)
   );

   // next state and the output values that go with it, so the registered
   // outputs always describe the state they are registered alongside
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      slot_nxt    = slot;
      h_nxt       = 1'b0;
      l_nxt       = 1'b0;
      hs_nxt      = 1'b0;
      ce_nxt      = 1'b0;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
      ser_data    = SYNC_BYTE;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nxt = S_HS_ZERO;
               cnt_nxt   = ZERO_LOAD;
               hs_nxt    = 1'b1;
               ce_nxt    = 1'b1;
            end
         end
         S_HS_ZERO: begin
            hs_nxt = 1'b1;
            ce_nxt = 1'b1;
            if (cnt == '0) begin
               state_nxt = S_SYNC;
               slot_nxt  = 2'd0;
               ser_load  = 1'b1;
               ser_data  = SYNC_BYTE;
               h_nxt     = ser_h;
               l_nxt     = ser_l;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_SYNC, S_DATA: begin
            hs_nxt = 1'b1;
            ce_nxt = 1'b1;
            if (!slot_last) begin
               slot_nxt    = slot + 2'd1;
               ser_advance = 1'b1;
               h_nxt       = ser_h;
               l_nxt       = ser_l;
            end else if (in_valid) begin
               state_nxt = S_DATA;
               slot_nxt  = 2'd0;
               ser_load  = 1'b1;
               ser_data  = in_data;
               h_nxt     = ser_h;
               l_nxt     = ser_l;
            end else begin
               // data_l currently carries bit 7 of the byte just sent
               state_nxt = S_TRAILER;
               cnt_nxt   = TRAIL_LOAD;
               h_nxt     = ~data_l;
               l_nxt     = ~data_l;
            end
         end
         S_TRAILER: begin
            ce_nxt = 1'b1;
            if (cnt == '0) begin
               state_nxt = S_POST;
               cnt_nxt   = POST_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
               hs_nxt  = 1'b1;
               h_nxt   = data_h;
               l_nxt   = data_l;
            end
         end
         S_POST: begin
            if (cnt == '0) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
               ce_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // state, counters and registered lane outputs
   always_ff @(posedge clock_p) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         slot         <= 2'd0;
         data_h       <= 1'b0;
         data_l       <= 1'b0;
         hs_active    <= 1'b0;
         clock_enable <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         slot         <= slot_nxt;
         data_h       <= h_nxt;
         data_l       <= l_nxt;
         hs_active    <= hs_nxt;
         clock_enable <= ce_nxt;
      end
   end

`ifdef D_PHY_TX_DISPLAY_EN
   // per-byte log in the receiver's format so the two logs can be diffed
   always @(posedge clock_p) begin
      if (!reset && in_valid && in_ready) begin
         $display("%h", in_data);
      end
   end
`else
`endif

endmodule

// File: tb/tb_d_phy_transmitter.sv
// Bench for d_phy_transmitter: a default-parameter instance and a
// minimum-parameter instance (1/1/1), driven one at a time. Expected outputs
// come from a phase/timeline model of a burst (exp_at), checked every clock.
module tb_d_phy_transmitter;

   logic       clock_p = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid0, in_valid1;
   logic       in_ready0, data_h0, data_l0, hs_active0, clock_enable0, busy0;
   logic       in_ready1, data_h1, data_l1, hs_active1, clock_enable1, busy1;

   always #5 clock_p = ~clock_p;

   d_phy_transmitter u_dut0 (
      .clock_p      (clock_p),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid0),
      .in_ready     (in_ready0),
      .data_h       (data_h0),
      .data_l       (data_l0),
      .hs_active    (hs_active0),
      .clock_enable (clock_enable0),
      .busy         (busy0)
   );

   d_phy_transmitter #(
      .ZERO_CYCLES     (1),
      .TRAIL_CYCLES    (1),
      .CLK_POST_CYCLES (1)
   ) u_dut1 (
      .clock_p      (clock_p),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid1),
      .in_ready     (in_ready1),
      .data_h       (data_h1),
      .data_l       (data_l1),
      .hs_active    (hs_active1),
      .clock_enable (clock_enable1),
      .busy         (busy1)
   );

   typedef struct {
      int         cyc;
      logic [5:0] v;
   } exp_t;

   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   int         sel   = 0;
   int         zc, tc, pc;
   logic [7:0] byte_q[$];
   exp_t       exp_q[$];

   always @(posedge clock_p) cyc <= cyc + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Expected {data_h, data_l, hs_active, clock_enable, in_ready, busy}
   // j clocks after the clock on which IDLE saw in_valid.
   function automatic logic [5:0] exp_at(input int j);
      int         n, d, m, k;
      logic [7:0] b;
      logic       lb;
      n = byte_q.size();
      d = zc + 4 + 4 * n;
      if (j <= 0) return 6'b0;
      if (j <= zc) return 6'b001101;
      if (j <= d) begin
         m = (j - zc - 1) % 4;
         k = (j - zc - 1) / 4;
         b = (k == 0) ? 8'hB8 : byte_q[k-1];
         return {b[2*m], b[2*m+1], 1'b1, 1'b1, (m == 3), 1'b1};
      end
      if (j <= d + tc) begin
         if (n == 0) lb = 1'b1;
         else begin
            b  = byte_q[n-1];
            lb = b[7];
         end
         return {~lb, ~lb, 1'b1, 1'b1, 1'b0, 1'b1};
      end
      if (j <= d + tc + pc) return 6'b000101;
      return 6'b0;
   endfunction

   // compare the selected instance against every expectation due this clock
   always @(negedge clock_p) begin
      logic [5:0] act;
      exp_t       e;
      string      nm [6];
      nm  = '{"data_h", "data_l", "hs_active", "clock_enable", "in_ready", "busy"};
      act = (sel == 0) ? {data_h0, data_l0, hs_active0, clock_enable0, in_ready0, busy0}
                       : {data_h1, data_l1, hs_active1, clock_enable1, in_ready1, busy1};
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         for (int i = 0; i < 6; i++) begin
            check($sformatf("%s dut%0d cyc%0d", nm[i], sel, e.cyc),
                  {7'b0, act[5-i]}, {7'b0, e.v[5-i]});
         end
      end
   end

   task automatic push_v(input logic [5:0] v);
      exp_t e;
      e.cyc = cyc + 1;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic set_valid(input logic v);
      in_valid0 = (sel == 0) ? v : 1'b0;
      in_valid1 = (sel == 1) ? v : 1'b0;
   endtask

   task automatic set_params(input int s);
      sel = s;
      zc  = (s == 0) ? 16 : 1;
      tc  = (s == 0) ? 4 : 1;
      pc  = (s == 0) ? 8 : 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         set_valid(1'b0);
         in_data = 8'($urandom);
         push_v(6'b0);
         @(posedge clock_p); #1;
      end
   endtask

   // One burst carrying byte_q; rst_at > 0 pulses reset during that clock.
   task automatic run_burst(input int rst_at);
      int n, d, len, k;
      n   = byte_q.size();
      d   = zc + 4 + 4 * n;
      len = d + tc + pc + 1;
      set_valid(1'b1);
      in_data = 8'($urandom);
      push_v(exp_at(1));
      for (int j = 1; j <= len; j++) begin
         @(posedge clock_p); #1;
         if (j == rst_at) begin
            reset = 1'b1;
            set_valid(1'($urandom_range(0, 1)));
            push_v(6'b0);
            @(posedge clock_p); #1;
            reset = 1'b0;
            set_valid(1'b0);
            return;
         end
         if (j == len) begin
            set_valid(1'b0);
            in_data = 8'($urandom);
         end else if (j >= zc + 4 && j <= d && ((j - zc - 4) % 4) == 0) begin
            k = (j - zc - 4) / 4;
            if (k < n) begin
               set_valid(1'b1);
               in_data = byte_q[k];
            end else begin
               set_valid(1'b0);
               in_data = 8'($urandom);
            end
         end else begin
            set_valid(1'($urandom_range(0, 1)));
            in_data = 8'($urandom);
         end
         if (j < len) push_v(exp_at(j + 1));
      end
   endtask

   initial begin
      int n, len, ra;
      reset     = 1'b1;
      in_data   = 8'h00;
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      set_params(0);
      byte_q = {};
      push_v(6'b0);
      @(posedge clock_p); #1;
      push_v(6'b0);
      @(posedge clock_p); #1;
      reset = 1'b0;
      idle(2);

      // hand-computed points that pin the model
      byte_q = '{8'h5A};
      check("pin sync slot3", 8'(exp_at(20)), 8'b011111);
      check("pin 5A pair0",   8'(exp_at(21)), 8'b011101);
      check("pin 5A pair3",   8'(exp_at(24)), 8'b101111);
      check("pin 5A trail",   8'(exp_at(25)), 8'b111101);
      check("pin 5A post",    8'(exp_at(36)), 8'b000101);
      check("pin 5A idle",    8'(exp_at(37)), 8'b000000);
      byte_q = {};
      check("pin nopay trail", 8'(exp_at(21)), 8'b001101);
      byte_q = '{8'h00, 8'hFF, 8'h0F};
      check("pin FF slot3",   8'(exp_at(28)), 8'b111111);
      check("pin 0F trail",   8'(exp_at(33)), 8'b111101);

      // single byte, back-to-back three, no payload
      byte_q = '{8'h5A};
      run_burst(-1);
      idle(1);
      byte_q = '{8'h00, 8'hFF, 8'h0F};
      run_burst(-1);
      idle(2);
      byte_q = {};
      run_burst(-1);
      idle(1);

      // reset in DATA slot 2 of the second byte, then a normal burst
      byte_q = '{8'h11, 8'h22, 8'h33};
      run_burst(zc + 11);
      idle(1);
      byte_q = '{8'hA5};
      run_burst(-1);
      idle(1);

      // 64 random bytes in one burst
      byte_q = {};
      for (int i = 0; i < 64; i++) byte_q.push_back(8'($urandom));
      run_burst(-1);
      idle(1);

      // minimum-length phases
      set_params(1);
      byte_q = '{8'h3C};
      run_burst(-1);
      byte_q = {};
      run_burst(-1);
      idle(1);

      // random bursts on either instance, occasional reset
      for (int it = 0; it < 10; it++) begin
         set_params(int'($urandom_range(0, 1)));
         byte_q = {};
         n = int'($urandom_range(0, 4));
         for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
         len = zc + 4 + 4 * n + tc + pc + 1;
         ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
         run_burst(ra);
         idle(int'($urandom_range(0, 2)));
         idle(1);
      end

      idle(2);
      #10;
      check("expectations drained", 8'(exp_q.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
